// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl -- Minesweeper game controller.
//
// Owns the game FSM (INIT/PLAY/WIN/LOSE), the cursor, the count of safe cells
// still covered, the placed-flag count and an elapsed-seconds timer. Turns
// debounced button pulses into registered open/flag request strobes for the
// board-cover array and feeds the display mux.
//
// Optional feature macro: CURSOR_WRAP_EN
//   defined   : cursor wraps around the board edges
//   undefined : edge presses are ignored (cursor clamps)
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   btn_l/u/d/r/c       single-cycle debounced button pulses
//   sw_flag             centre press toggles a flag instead of opening
//   sw_new              centre press restarts the game (any state)
//   init_busy           board generator still running (0 = ready)
//   num_non_mines       safe-cell count of the generated board
//   cell_val            apparent value under the cursor (5'b11111 = mine hit)
//   opened_cell         pulse: cover array opened one more cell
//   flag_changed        pulse: flag toggled at cursor
//   flag_added          qualifies flag_changed (1 = placed, 0 = removed)
//   x_coord, y_coord    cursor position
//   state               one-hot INIT=0001 PLAY=0010 WIN=0100 LOSE=1000
//   open_req, flag_req  registered one-cycle request strobes
//   cells_to_open       safe cells still covered
//   flags_placed        current flag count
//   timer_sec           elapsed seconds (saturating)
// ---------------------------------------------------------------------------
module game_ctrl #(
    parameter int X_SIZE   = 16,
    parameter int Y_SIZE   = 16,
    parameter int X_BITS   = 4,
    parameter int Y_BITS   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int TIMER_W  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_l,
    input  logic                     btn_u,
    input  logic                     btn_d,
    input  logic                     btn_r,
    input  logic                     btn_c,
    input  logic                     sw_flag,
    input  logic                     sw_new,
    input  logic                     init_busy,
    input  logic [X_BITS+Y_BITS:0]   num_non_mines,
    input  logic [4:0]               cell_val,
    input  logic                     opened_cell,
    input  logic                     flag_changed,
    input  logic                     flag_added,
    output logic [X_BITS-1:0]        x_coord,
    output logic [Y_BITS-1:0]        y_coord,
    output logic [3:0]               state,
    output logic                     open_req,
    output logic                     flag_req,
    output logic [X_BITS+Y_BITS:0]   cells_to_open,
    output logic [X_BITS+Y_BITS:0]   flags_placed,
    output logic [TIMER_W-1:0]       timer_sec
);

    localparam int CW = X_BITS + Y_BITS + 1;
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [X_BITS-1:0]  X_MAX     = X_BITS'(X_SIZE - 1);
    localparam logic [Y_BITS-1:0]  Y_MAX     = Y_BITS'(Y_SIZE - 1);
    localparam logic [CW-1:0]      FLAGS_MAX = CW'(X_SIZE * Y_SIZE);
    localparam logic [PW-1:0]      PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;
    localparam logic [4:0]         MINE_HIT  = 5'b11111;

    typedef enum logic [3:0] {
        S_INIT = 4'b0001,
        S_PLAY = 4'b0010,
        S_WIN  = 4'b0100,
        S_LOSE = 4'b1000
    } state_t;

    state_t              state_q, state_d;
    logic [X_BITS-1:0]   x_q, x_d;
    logic [Y_BITS-1:0]   y_q, y_d;
    logic [CW-1:0]       cells_q, cells_d;
    logic [CW-1:0]       flags_q, flags_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                armed_q, armed_d;   // timer runs once the first open is issued
    logic                open_req_q, open_req_d;
    logic                flag_req_q, flag_req_d;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cells_d    = cells_q;
        flags_d    = flags_q;
        timer_d    = timer_q;
        presc_d    = presc_q;
        armed_d    = armed_q;
        open_req_d = 1'b0;
        flag_req_d = 1'b0;

        if (btn_c && sw_new) begin
            // Soft restart: same values as the hard reset.
            state_d = S_INIT;
            x_d     = '0;
            y_d     = '0;
            cells_d = '0;
            flags_d = '0;
            timer_d = '0;
            presc_d = '0;
            armed_d = 1'b0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    flags_d = '0;
                    timer_d = '0;
                    presc_d = '0;
                    armed_d = 1'b0;
                    if (!init_busy) begin
                        cells_d = num_non_mines;
                        state_d = S_PLAY;
                    end
                end

                S_PLAY: begin
                    // Exit takes the whole cycle: nothing else updates and no
                    // strobe is issued, so strobes never appear outside PLAY.
                    if (cell_val == MINE_HIT) begin
                        state_d = S_LOSE;
                    end else if (cells_q == '0) begin
                        state_d = S_WIN;
                    end else begin
                        // Opposing presses in the same cycle cancel out.
                        if (btn_l && !btn_r) begin
                            if (x_q != '0) x_d = x_q - 1'b1;
`ifdef CURSOR_WRAP_EN
                            else           x_d = X_MAX;
`endif
                        end else if (btn_r && !btn_l) begin
                            if (x_q < X_MAX) x_d = x_q + 1'b1;
`ifdef CURSOR_WRAP_EN
                            else             x_d = '0;
`endif
                        end

                        if (btn_u && !btn_d) begin
                            if (y_q != '0) y_d = y_q - 1'b1;
`ifdef CURSOR_WRAP_EN
                            else           y_d = Y_MAX;
`endif
                        end else if (btn_d && !btn_u) begin
                            if (y_q < Y_MAX) y_d = y_q + 1'b1;
`ifdef CURSOR_WRAP_EN
                            else             y_d = '0;
`endif
                        end

                        open_req_d = btn_c && !sw_flag;
                        flag_req_d = btn_c && sw_flag;

                        if (opened_cell && cells_q != '0) cells_d = cells_q - 1'b1;

                        if (flag_changed) begin
                            if (flag_added) begin
                                if (flags_q < FLAGS_MAX) flags_d = flags_q + 1'b1;
                            end else begin
                                if (flags_q != '0) flags_d = flags_q - 1'b1;
                            end
                        end

                        if (armed_q) begin
                            if (presc_q == PRESC_MAX) begin
                                presc_d = '0;
                                if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
                            end else begin
                                presc_d = presc_q + 1'b1;
                            end
                        end
                        armed_d = armed_q | open_req_d;
                    end
                end

                S_WIN, S_LOSE: begin
                    if (btn_c) begin
                        state_d = S_INIT;
                        flags_d = '0;
                        timer_d = '0;
                        presc_d = '0;
                        armed_d = 1'b0;
                    end
                end

                default: state_d = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_INIT;
            x_q        <= '0;
            y_q        <= '0;
            cells_q    <= '0;
            flags_q    <= '0;
            timer_q    <= '0;
            presc_q    <= '0;
            armed_q    <= 1'b0;
            open_req_q <= 1'b0;
            flag_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cells_q    <= cells_d;
            flags_q    <= flags_d;
            timer_q    <= timer_d;
            presc_q    <= presc_d;
            armed_q    <= armed_d;
            open_req_q <= open_req_d;
            flag_req_q <= flag_req_d;
        end
    end

    assign state         = state_q;
    assign x_coord       = x_q;
    assign y_coord       = y_q;
    assign cells_to_open = cells_q;
    assign flags_placed  = flags_q;
    assign timer_sec     = timer_q;
    assign open_req      = open_req_q;
    assign flag_req      = flag_req_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Testbench for game_ctrl on a 4x4 board with a 10-cycle second and a 4-bit
// timer. Each driven cycle runs the reference model and queues the expected
// outputs; a monitor compares them one cycle later. A few directed steps also
// check fixed values from the test plan.
module tb_game_ctrl;

    localparam int XS = 4, YS = 4, XB = 2, YB = 2, TD = 10, TW = 4;
    localparam int TMAXI = 15, FMAX = XS * YS;
    localparam int ST_INIT = 0, ST_PLAY = 1, ST_WIN = 2, ST_LOSE = 3;

    logic clk = 1'b0;
    logic reset, btn_l, btn_u, btn_d, btn_r, btn_c, sw_flag, sw_new, init_busy;
    logic [XB+YB:0] num_non_mines;
    logic [4:0] cell_val;
    logic opened_cell, flag_changed, flag_added;
    logic [XB-1:0] x_coord;
    logic [YB-1:0] y_coord;
    logic [3:0] state;
    logic open_req, flag_req;
    logic [XB+YB:0] cells_to_open, flags_placed;
    logic [TW-1:0] timer_sec;

    game_ctrl #(.X_SIZE(XS), .Y_SIZE(YS), .X_BITS(XB), .Y_BITS(YB),
                .TICK_DIV(TD), .TIMER_W(TW)) dut (
        .clk(clk), .reset(reset),
        .btn_l(btn_l), .btn_u(btn_u), .btn_d(btn_d), .btn_r(btn_r), .btn_c(btn_c),
        .sw_flag(sw_flag), .sw_new(sw_new), .init_busy(init_busy),
        .num_non_mines(num_non_mines), .cell_val(cell_val),
        .opened_cell(opened_cell), .flag_changed(flag_changed), .flag_added(flag_added),
        .x_coord(x_coord), .y_coord(y_coord), .state(state),
        .open_req(open_req), .flag_req(flag_req),
        .cells_to_open(cells_to_open), .flags_placed(flags_placed), .timer_sec(timer_sec)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit rst, l, u, d, r, c, sf, sn, busy, oc, fc, fa;
        int nnm;
        int cv;
    } in_t;

    typedef struct {
        logic [3:0]     st;
        logic [XB-1:0]  x;
        logic [YB-1:0]  y;
        logic [XB+YB:0] cells;
        logic [XB+YB:0] flags;
        logic [TW-1:0]  tmr;
        logic           op;
        logic           fl;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state (plain integers).
    int m_st = ST_INIT, m_x = 0, m_y = 0, m_cells = 0, m_flags = 0;
    int m_timer = 0, m_presc = 0;
    bit m_armed = 0, m_op = 0, m_fl = 0;

    function automatic int move(input int p, input int dir, input int size);
        if (dir < 0) begin
            if (p > 0) return p - 1;
`ifdef CURSOR_WRAP_EN
            return size - 1;
`else
            return p;
`endif
        end
        if (dir > 0) begin
            if (p < size - 1) return p + 1;
`ifdef CURSOR_WRAP_EN
            return 0;
`else
            return p;
`endif
        end
        return p;
    endfunction

    task automatic clear_game();
        m_flags = 0; m_timer = 0; m_presc = 0; m_armed = 0;
    endtask

    task automatic model_step(input in_t i);
        exp_t e;
        m_op = 0;
        m_fl = 0;
        if (i.rst || (i.c && i.sn)) begin
            m_st = ST_INIT; m_x = 0; m_y = 0; m_cells = 0;
            clear_game();
        end else if (m_st == ST_INIT) begin
            clear_game();
            if (!i.busy) begin
                m_cells = i.nnm;
                m_st = ST_PLAY;
            end
        end else if (m_st == ST_PLAY) begin
            if (i.cv == 31) m_st = ST_LOSE;
            else if (m_cells == 0) m_st = ST_WIN;
            else begin
                m_x = move(m_x, int'(i.r) - int'(i.l), XS);
                m_y = move(m_y, int'(i.d) - int'(i.u), YS);
                if (m_armed) begin
                    m_presc++;
                    if (m_presc == TD) begin
                        m_presc = 0;
                        if (m_timer < TMAXI) m_timer++;
                    end
                end
                m_op = i.c && !i.sf;
                m_fl = i.c && i.sf;
                if (m_op) m_armed = 1;
                if (i.oc && m_cells > 0) m_cells--;
                if (i.fc) begin
                    if (i.fa) begin
                        if (m_flags < FMAX) m_flags++;
                    end else if (m_flags > 0) m_flags--;
                end
            end
        end else if (i.c) begin
            m_st = ST_INIT;
            clear_game();
        end
        e.st = 4'(1 << m_st);
        e.x = XB'(m_x);
        e.y = YB'(m_y);
        e.cells = 5'(m_cells);
        e.flags = 5'(m_flags);
        e.tmr = TW'(m_timer);
        e.op = m_op;
        e.fl = m_fl;
        sb.push_back(e);
    endtask

    function automatic in_t idle();
        in_t i;
        i = '0;
        return i;
    endfunction

    task automatic step(input in_t i);
        reset = i.rst; btn_l = i.l; btn_u = i.u; btn_d = i.d; btn_r = i.r;
        btn_c = i.c; sw_flag = i.sf; sw_new = i.sn; init_busy = i.busy;
        num_non_mines = 5'(i.nnm); cell_val = 5'(i.cv);
        opened_cell = i.oc; flag_changed = i.fc; flag_added = i.fa;
        model_step(i);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: one expected snapshot per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (state !== e.st || x_coord !== e.x || y_coord !== e.y ||
                    cells_to_open !== e.cells || flags_placed !== e.flags ||
                    timer_sec !== e.tmr || open_req !== e.op || flag_req !== e.fl) begin
                    failures++;
                    $display("FAIL cycle%0d: got st=%b x=%0d y=%0d cells=%0d flags=%0d tmr=%0d op=%b fl=%b expected st=%b x=%0d y=%0d cells=%0d flags=%0d tmr=%0d op=%b fl=%b",
                             cyc, state, x_coord, y_coord, cells_to_open, flags_placed, timer_sec,
                             open_req, flag_req, e.st, e.x, e.y, e.cells, e.flags, e.tmr, e.op, e.fl);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_t i;
        // Reset and board generation.
        i = idle(); i.rst = 1; i.busy = 1; step(i);
        chk("reset_state", state, 4'b0001);
        chk("reset_x", x_coord, 0);
        chk("reset_cells", cells_to_open, 0);
        chk("reset_timer", timer_sec, 0);
        i = idle(); i.busy = 1; step(i); step(i);
        chk("init_hold", state, 4'b0001);
        i = idle(); i.nnm = 13; step(i);
        chk("play_entry", state, 4'b0010);
        chk("cells_load", cells_to_open, 13);

        // Cursor edges.
        i = idle(); i.l = 1; step(i);
        i = idle(); i.u = 1; step(i);
        chk("corner_x", x_coord, 0);
        chk("corner_y", y_coord, 0);
        repeat (5) begin i = idle(); i.r = 1; step(i); end
`ifdef CURSOR_WRAP_EN
        chk("right_5", x_coord, 1);
`else
        chk("right_5", x_coord, 3);
`endif
        i = idle(); i.l = 1; i.r = 1; i.u = 1; i.d = 1; step(i);

        // Open strobe, opening, timer.
        i = idle(); i.c = 1; step(i);
        chk("open_req_hi", open_req, 1);
        chk("flag_req_lo", flag_req, 0);
        i = idle(); step(i);
        chk("open_req_lo", open_req, 0);
        i = idle(); i.oc = 1; i.cv = 3; step(i);
        chk("cells_dec", cells_to_open, 12);
        repeat (25) step(idle());
        chk("timer_2", timer_sec, 2);

        // Flags.
        repeat (3) begin i = idle(); i.fc = 1; i.fa = 1; step(i); end
        i = idle(); i.fc = 1; step(i);
        chk("flags_2", flags_placed, 2);
        repeat (3) begin i = idle(); i.fc = 1; step(i); end
        chk("flags_floor", flags_placed, 0);
        repeat (18) begin i = idle(); i.fc = 1; i.fa = 1; step(i); end
        chk("flags_ceiling", flags_placed, 16);
        i = idle(); i.c = 1; i.sf = 1; step(i);
        chk("flag_req_hi", flag_req, 1);

        // Win.
        repeat (12) begin i = idle(); i.oc = 1; i.cv = 1; step(i); end
        chk("cells_zero", cells_to_open, 0);
        step(idle());
        chk("win", state, 4'b0100);
        i = idle(); i.l = 1; i.fc = 1; i.fa = 1; step(i);
        repeat (12) step(idle());
        chk("win_timer_frozen", timer_sec, 32'(m_timer));
        chk("win_flags_frozen", flags_placed, 16);
`ifdef CURSOR_WRAP_EN
        chk("win_x_frozen", x_coord, 1);
`else
        chk("win_x_frozen", x_coord, 3);
`endif
        i = idle(); i.c = 1; step(i);
        chk("win_to_init", state, 4'b0001);
        chk("init_timer_clr", timer_sec, 0);

        // Loss wins over the final opening.
        i = idle(); i.nnm = 1; step(i);
        chk("play_1cell", cells_to_open, 1);
        i = idle(); i.oc = 1; i.cv = 31; step(i);
        chk("lose", state, 4'b1000);
        chk("lose_no_strobe", open_req, 0);
        i = idle(); i.c = 1; i.sn = 1; step(i);
        chk("soft_rst_state", state, 4'b0001);
        chk("soft_rst_x", x_coord, 0);
        chk("soft_rst_cells", cells_to_open, 0);

        // Timer saturation.
        i = idle(); i.rst = 1; step(i);
        i = idle(); i.nnm = 16; step(i);
        i = idle(); i.c = 1; step(i);
        repeat (170) step(idle());
        chk("timer_sat", timer_sec, 15);

        // Randomised play.
        for (int n = 0; n < 3000; n++) begin
            i = idle();
            i.rst  = ($urandom_range(0, 999) < 3);
            i.busy = ($urandom_range(0, 3) == 0);
            i.nnm  = $urandom_range(1, 16);
            i.l    = ($urandom_range(0, 4) == 0);
            i.r    = ($urandom_range(0, 4) == 0);
            i.u    = ($urandom_range(0, 4) == 0);
            i.d    = ($urandom_range(0, 4) == 0);
            i.c    = ($urandom_range(0, 7) == 0);
            i.sf   = $urandom_range(0, 1);
            i.sn   = ($urandom_range(0, 15) == 0);
            i.oc   = ($urandom_range(0, 3) == 0);
            i.cv   = ($urandom_range(0, 59) == 0) ? 31 : $urandom_range(0, 8);
            i.fc   = ($urandom_range(0, 4) == 0);
            i.fa   = ($urandom_range(0, 2) != 0);
            step(i);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
